// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op codes, exception codes,
// bus direction encoding and the bus FSM state type.
package mem_stage_pkg;

   localparam logic [1:0] MEM_OP_NOP = 2'd0;
   localparam logic [1:0] MEM_OP_LDW = 2'd1;
   localparam logic [1:0] MEM_OP_STW = 2'd2;

   localparam logic [2:0] EXP_NO         = 3'h0;
   localparam logic [2:0] EXP_MISS_ALIGN = 3'h4;

   localparam logic BUS_RW_READ  = 1'b1;
   localparam logic BUS_RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      BUS_IDLE   = 2'd0,
      BUS_REQ    = 2'd1,
      BUS_ACCESS = 2'd2,
      BUS_STALL  = 2'd3
   } bus_state_t;

   // Op code 3 is reserved and behaves like a NOP.
   function automatic logic is_mem_access(input logic [1:0] op);
      case (op)
         MEM_OP_LDW, MEM_OP_STW: return 1'b1;
         MEM_OP_NOP:             return 1'b0;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// Bus master for the memory stage: req/grant/strobe/ready handshake, read
// buffer, busy generation and the load-data forwarding mux.
module bus_if
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        access,
   input  logic        is_load,
   input  logic [29:0] addr,
   input  logic [31:0] wr_data,
   input  logic [31:0] ex_out,
   output logic [31:0] fwd_data,
   output logic        busy,
   output logic        bus_req_,
   input  logic        bus_grnt_,
   output logic [29:0] bus_addr,
   output logic        bus_as_,
   output logic        bus_rw,
   output logic [31:0] bus_wr_data,
   input  logic [31:0] bus_rd_data,
   input  logic        bus_rdy_
);

   bus_state_t  state, state_nxt;
   logic [31:0] rd_buf;
   logic        rd_buf_we;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= BUS_IDLE;
         rd_buf <= '0;
      end else begin
         state <= state_nxt;
         if (rd_buf_we) rd_buf <= bus_rd_data;
      end
   end

   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      bus_req_    = 1'b1;
      bus_as_     = 1'b1;
      bus_rw      = BUS_RW_READ;
      bus_addr    = '0;
      bus_wr_data = '0;
      rd_buf_we   = 1'b0;
      fwd_data    = ex_out;
      case (state)
         BUS_IDLE: begin
            // Gated by reset so an asserted reset releases the bus at once.
            if (access && reset) begin
               bus_req_  = 1'b0;
               busy      = 1'b1;
               state_nxt = BUS_REQ;
            end
         end
         BUS_REQ: begin
            bus_req_ = 1'b0;
            busy     = 1'b1;
            if (!bus_grnt_) begin
               bus_as_     = 1'b0;
               bus_addr    = addr;
               bus_rw      = is_load ? BUS_RW_READ : BUS_RW_WRITE;
               bus_wr_data = wr_data;
               state_nxt   = BUS_ACCESS;
            end
         end
         BUS_ACCESS: begin
            if (bus_rdy_) begin
               bus_req_ = 1'b0;
               busy     = 1'b1;
            end else begin
               rd_buf_we = 1'b1;
               if (is_load) fwd_data = bus_rd_data;
               state_nxt = stall ? BUS_STALL : BUS_IDLE;
            end
         end
         BUS_STALL: begin
            fwd_data = rd_buf;
            if (!stall) state_nxt = BUS_IDLE;
         end
         default: state_nxt = BUS_IDLE;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: alignment check, bus access through bus_if,
// and the MEM/WB output register.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   output logic        busy,
   input  logic [29:0] ex_pc,
   input  logic        ex_en,
   input  logic        ex_br_flag,
   input  logic [1:0]  ex_mem_op,
   input  logic [31:0] ex_mem_wr_data,
   input  logic [1:0]  ex_ctrl_op,
   input  logic [4:0]  ex_dst_addr,
   input  logic        ex_gpr_we_,
   input  logic [2:0]  ex_exp_code,
   input  logic [31:0] ex_out,
   output logic [31:0] fwd_data,
   output logic [29:0] mem_pc,
   output logic        mem_en,
   output logic        mem_br_flag,
   output logic [1:0]  mem_ctrl_op,
   output logic [4:0]  mem_dst_addr,
   output logic        mem_gpr_we_,
   output logic [2:0]  mem_exp_code,
   output logic [31:0] mem_out,
   output logic        bus_req_,
   input  logic        bus_grnt_,
   output logic [29:0] bus_addr,
   output logic        bus_as_,
   output logic        bus_rw,
   output logic [31:0] bus_wr_data,
   input  logic [31:0] bus_rd_data,
   input  logic        bus_rdy_
);

   logic miss_align;
   logic access;
   logic is_load;

   assign miss_align = is_mem_access(ex_mem_op) && (ex_out[1:0] != 2'b00);
   assign access     = ex_en && is_mem_access(ex_mem_op) && !miss_align && !flush;
   assign is_load    = (ex_mem_op == MEM_OP_LDW);

   bus_if u_bus_if (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .access      (access),
      .is_load     (is_load),
      .addr        (ex_out[31:2]),
      .wr_data     (ex_mem_wr_data),
      .ex_out      (ex_out),
      .fwd_data    (fwd_data),
      .busy        (busy),
      .bus_req_    (bus_req_),
      .bus_grnt_   (bus_grnt_),
      .bus_addr    (bus_addr),
      .bus_as_     (bus_as_),
      .bus_rw      (bus_rw),
      .bus_wr_data (bus_wr_data),
      .bus_rd_data (bus_rd_data),
      .bus_rdy_    (bus_rdy_)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_pc       <= '0;
         mem_en       <= 1'b0;
         mem_br_flag  <= 1'b0;
         mem_ctrl_op  <= '0;
         mem_dst_addr <= '0;
         mem_gpr_we_  <= 1'b1;
         mem_exp_code <= EXP_NO;
         mem_out      <= '0;
      end else if (!stall) begin
         if (flush) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= EXP_NO;
            mem_out      <= '0;
         end else if (miss_align) begin
            // Misaligned access becomes an exception with no side effects.
            mem_pc       <= ex_pc;
            mem_en       <= ex_en;
            mem_br_flag  <= ex_br_flag;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= EXP_MISS_ALIGN;
            mem_out      <= '0;
         end else begin
            mem_pc       <= ex_pc;
            mem_en       <= ex_en;
            mem_br_flag  <= ex_br_flag;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= ex_gpr_we_;
            mem_exp_code <= ex_exp_code;
            mem_out      <= fwd_data;
         end
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; consumes the EX/MEM register outputs (ex_*) and produces the MEM/WB register outputs (mem_*).
- Performs word loads/stores over the shared bus through a req/grant master handshake.
- Detects misaligned accesses and forwards its result (fwd_data).
- Raises busy to stall the pipeline while a bus transaction is outstanding.

Parameters:
- None. Widths are fixed by the ISA: 32-bit data, 30-bit word address.

Ports:
- clk  in  1  Clock; all state on the rising edge.
- reset  in  1  Asynchronous, active-low reset.
- stall  in  1  Pipeline stall; holds the output register.
- flush  in  1  Pipeline flush; output register becomes a bubble.
- busy  out  1  High while a bus access is pending; feeds the pipeline controller.
- ex_pc  in  30  PC of the instruction in EX/MEM.
- ex_en  in  1  EX/MEM entry valid.
- ex_br_flag  in  1  Branch flag.
- ex_mem_op  in  2  Memory op: 0 NOP, 1 LDW, 2 STW (3 is treated as NOP).
- ex_mem_wr_data  in  32  Store data.
- ex_ctrl_op  in  2  Control op, passed through.
- ex_dst_addr  in  5  Destination GPR.
- ex_gpr_we_  in  1  GPR write enable, active-low.
- ex_exp_code  in  3  Exception code from earlier stages.
- ex_out  in  32  ALU result, used as the byte address for memory ops.
- fwd_data  out  32  Combinational stage result for forwarding.
- mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out  out  30/1/1/2/5/1/3/32  MEM/WB register.
- bus_req_  out  1  Bus request, active-low.
- bus_grnt_  in  1  Bus grant, active-low.
- bus_addr  out  30  Word address.
- bus_as_  out  1  Address strobe, active-low.
- bus_rw  out  1  1 = read, 0 = write.
- bus_wr_data  out  32  Write data.
- bus_rd_data  in  32  Read data.
- bus_rdy_  in  1  Slave ready, active-low.

Behaviour:
- Access request:
  - miss_align = (mem_op is LDW or STW) and ex_out[1:0] != 0.
  - access = ex_en and mem_op in {LDW, STW} and !miss_align and !flush.
- Combinational result: fwd_data = bus_rd_data when LDW completes this cycle; rd_buf in STALL state; otherwise ex_out.
- Bus FSM states:
  - IDLE (reset state): on access, bus_req_=0, busy=1 -> REQ.
  - REQ: busy=1. When bus_grnt_=0, drive bus_as_=0, bus_addr=ex_out[31:2], bus_rw=(LDW), bus_wr_data=ex_mem_wr_data for exactly one cycle -> ACCESS.
  - ACCESS: bus_as_=1, busy=1 until bus_rdy_=0. In the rdy cycle:
    - busy=0, bus_req_=1.
    - rd_buf <= bus_rd_data.
    - Next state is STALL if stall=1, else IDLE.
  - STALL: busy=0, fwd_data=rd_buf; -> IDLE when stall=0.
- Bus output idle values: bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0.
- Flush during REQ/ACCESS does not abort the bus cycle; the FSM completes the handshake and only the register result is discarded.
- Output register, async reset (reset=0):
  - mem_pc=0, mem_en=0, mem_br_flag=0, mem_ctrl_op=0.
  - mem_dst_addr=0, mem_gpr_we_=1, mem_exp_code=0, mem_out=0.
- Output register, per clk edge:
  - stall=1: hold all outputs.
  - flush=1: load reset values.
  - miss_align: mem_en=ex_en, mem_pc=ex_pc, mem_exp_code=MISS_ALIGN (3'h4), mem_gpr_we_=1, mem_ctrl_op=0, mem_out=0.
  - otherwise: copy ex_* to mem_*, mem_out=fwd_data.
- A load or store completes in ≥3 cycles (IDLE->REQ->ACCESS, with grant and rdy each in 0 wait cycles). busy is combinational so the pipeline freezes in the request cycle itself.
- A reset asserted mid-transaction returns the FSM to IDLE and releases the bus immediately.

Decomposition:
- Shared package holds:
  - MEM_OP_{NOP,LDW,STW}
  - EXP codes (NO=0, MISS_ALIGN=4)
  - BUS_RW_{READ=1,WRITE=0}
  - bus FSM state encoding
- One sub-module, bus_if: FSM, rd_buf, bus drive, busy, load-data mux.
- mem_stage contains the alignment check and the output register (mem_reg).

Test Plan:
- LDW addr 0x100, grant after 2 cycles, rdy 1 cycle later with 0xDEADBEEF:
  - bus_addr=0x40, bus_rw=1, bus_as_ low for exactly 1 cycle.
  - busy high throughout and low in the rdy cycle.
  - mem_out=0xDEADBEEF next edge.
- STW addr 0x8, data 0x12345678, immediate grant/rdy:
  - bus_rw=0, bus_wr_data=0x12345678, bus_addr=0x2.
  - mem_gpr_we_ passes through from ex_gpr_we_.
- LDW addr 0x102:
  - no bus_req_.
  - mem_exp_code=4, mem_gpr_we_=1, mem_ctrl_op=0.
- LDW completes while stall=1 for 3 cycles:
  - FSM in STALL.
  - fwd_data=rd_buf value held.
  - mem_out updates only after stall drops.
- Flush asserted in ACCESS:
  - bus handshake completes.
  - mem_en=0, mem_gpr_we_=1.
- reset low during REQ:
  - bus_req_=1, busy=0 immediately.
  - all mem_* at reset values.
